// File: rtl/puf_ctrl_pkg.sv
// Shared definitions for the arbiter-PUF evaluation sequencer:
// FSM encoding, synchroniser depth and vote-counter sizing.
package puf_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int SYNC_STAGES = 2;

    // Enough bits to hold every count from 0 to n_votes inclusive.
    function automatic int vote_cnt_width(input int n_votes);
        return (n_votes < 1) ? 1 : $clog2(n_votes + 1);
    endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// One chain's vote tally: synchronises the asynchronous arbiter output and
// accumulates it on each sample strobe, exposing post-update vote flags.
module puf_vote_counter
    import puf_ctrl_pkg::*;
#(
    parameter int N_VOTES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic resp_i,
    input  logic clr_i,
    input  logic sample_i,
    output logic maj_next_o,
    output logic unstable_next_o
);

    localparam int CW = vote_cnt_width(N_VOTES);
    localparam logic [CW-1:0] HALF = CW'(N_VOTES / 2);
    localparam logic [CW-1:0] FULL = CW'(N_VOTES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (sample_i) begin
            cnt_d = cnt_q + CW'(sync_q[SYNC_STAGES-1]);
        end
    end

    // Flags reflect the count including this cycle's sample, so the top can
    // latch the final verdict on the same edge as the last vote.
    assign maj_next_o      = (cnt_d > HALF);
    assign unstable_next_o = (cnt_d != '0) && (cnt_d != FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], resp_i};
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequencer for a bank of arbiter-PUF chains: fires every chain N_VOTES times
// per challenge, majority-votes each chain and returns bits, XOR and instability.
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int N_STAGES   = 8,
    parameter int N_CHAINS   = 8,
    parameter int N_VOTES    = 5,
    parameter int SETTLE_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [N_STAGES-1:0] req_challenge,
    output logic                puf_trigger,
    output logic [N_STAGES-1:0] puf_challenge,
    input  logic [N_CHAINS-1:0] puf_resp,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [N_CHAINS-1:0] resp_bits,
    output logic                resp_xor,
    output logic [N_CHAINS-1:0] resp_unstable
);

    if ((N_VOTES < 1) || (N_VOTES % 2 == 0)) begin : g_bad_votes
        $error("puf_eval_ctrl: N_VOTES must be odd and >= 1");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("puf_eval_ctrl: SETTLE_CYC must be >= 1");
    end

    // The trigger-high phase is stretched by the synchroniser depth so the
    // sampled bit belongs to the current evaluation.
    localparam int HIGH_CYC = SETTLE_CYC + SYNC_STAGES;
    localparam int TW       = $clog2(HIGH_CYC + 1);
    localparam int VW       = vote_cnt_width(N_VOTES);

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [VW-1:0]       vote_q, vote_d;
    logic [N_STAGES-1:0] challenge_q;
    logic                trigger_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic [N_CHAINS-1:0] resp_bits_q;
    logic [N_CHAINS-1:0] resp_unstable_q;
    logic                resp_xor_q;

    logic                accept;
    logic                clr_votes;
    logic                sample;
    logic [N_CHAINS-1:0] maj_next;
    logic [N_CHAINS-1:0] unstable_next;

    for (genvar gi = 0; gi < N_CHAINS; gi++) begin : g_chain
        puf_vote_counter #(
            .N_VOTES(N_VOTES)
        ) u_cnt (
            .clk             (clk),
            .rst             (rst),
            .resp_i          (puf_resp[gi]),
            .clr_i           (clr_votes),
            .sample_i        (sample),
            .maj_next_o      (maj_next[gi]),
            .unstable_next_o (unstable_next[gi])
        );
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        vote_d    = vote_q;
        accept    = 1'b0;
        clr_votes = 1'b0;
        sample    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    accept    = 1'b1;
                    clr_votes = 1'b1;
                    vote_d    = '0;
                    timer_d   = '0;
                    state_d   = ST_LOW;
                end
            end
            ST_LOW: begin
                if (timer_q == TW'(SETTLE_CYC - 1)) begin
                    timer_d = '0;
                    state_d = ST_HIGH;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_HIGH: begin
                if (timer_q == TW'(HIGH_CYC - 1)) begin
                    sample  = 1'b1;
                    timer_d = '0;
                    vote_d  = vote_q + VW'(1);
                    state_d = (vote_q == VW'(N_VOTES - 1)) ? ST_DONE : ST_LOW;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE: begin
                if (resp_valid_q && resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            timer_q         <= '0;
            vote_q          <= '0;
            challenge_q     <= '0;
            trigger_q       <= 1'b0;
            req_ready_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_bits_q     <= '0;
            resp_unstable_q <= '0;
            resp_xor_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            vote_q      <= vote_d;
            trigger_q   <= (state_d == ST_HIGH);
            req_ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                challenge_q <= req_challenge;
            end
            if ((state_q == ST_HIGH) && (state_d == ST_DONE)) begin
                resp_valid_q    <= 1'b1;
                resp_bits_q     <= maj_next;
                resp_unstable_q <= unstable_next;
                resp_xor_q      <= ^maj_next;
            end else if ((state_q == ST_DONE) && (state_d == ST_IDLE)) begin
                resp_valid_q    <= 1'b0;
                resp_bits_q     <= '0;
                resp_unstable_q <= '0;
                resp_xor_q      <= 1'b0;
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign puf_trigger   = trigger_q;
    assign puf_challenge = challenge_q;
    assign resp_valid    = resp_valid_q;
    assign resp_bits     = resp_bits_q;
    assign resp_xor      = resp_xor_q;
    assign resp_unstable = resp_unstable_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl: default configuration plus a single-vote,
// fast-settle, four-chain instance.
module tb_puf_eval_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_challenge = '0;
    logic       puf_trigger;
    logic [7:0] puf_challenge;
    logic [7:0] puf_resp;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] resp_bits;
    logic       resp_xor;
    logic [7:0] resp_unstable;

    logic       req_valid2 = 1'b0;
    logic       req_ready2;
    logic [7:0] req_challenge2 = '0;
    logic       puf_trigger2;
    logic [7:0] puf_challenge2;
    logic [3:0] puf_resp2 = '0;
    logic       resp_valid2;
    logic       resp_ready2 = 1'b0;
    logic [3:0] resp_bits2;
    logic       resp_xor2;
    logic [3:0] resp_unstable2;

    int checks = 0;
    int errors = 0;

    // Chain response model: pattern entry selected by votes completed since base.
    logic [7:0] pat [8];
    int         fall_count = 0;
    int         base = 0;
    logic       trig_prev = 1'b0;

    assign puf_resp = pat[(fall_count - base) & 7];

    always @(posedge clk) begin
        if (trig_prev && !puf_trigger) fall_count <= fall_count + 1;
        trig_prev <= puf_trigger;
    end

    always #5 clk = ~clk;

    puf_eval_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_challenge (req_challenge),
        .puf_trigger   (puf_trigger),
        .puf_challenge (puf_challenge),
        .puf_resp      (puf_resp),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_bits     (resp_bits),
        .resp_xor      (resp_xor),
        .resp_unstable (resp_unstable)
    );

    puf_eval_ctrl #(
        .N_STAGES   (8),
        .N_CHAINS   (4),
        .N_VOTES    (1),
        .SETTLE_CYC (1)
    ) dut2 (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid2),
        .req_ready     (req_ready2),
        .req_challenge (req_challenge2),
        .puf_trigger   (puf_trigger2),
        .puf_challenge (puf_challenge2),
        .puf_resp      (puf_resp2),
        .resp_valid    (resp_valid2),
        .resp_ready    (resp_ready2),
        .resp_bits     (resp_bits2),
        .resp_xor      (resp_xor2),
        .resp_unstable (resp_unstable2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns after the accepting posedge.
    task automatic send_req(input logic [7:0] c);
        int n;
        req_challenge = c;
        req_valid     = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until resp_valid; also watches
    // that puf_challenge holds the accepted value.
    task automatic wait_resp(input logic [7:0] c, output int lat, output logic chal_ok);
        lat = 0;
        chal_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (puf_challenge !== c) chal_ok = 1'b0;
        end while (!resp_valid && lat < 200);
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_valid_drop", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int         lat;
        logic       chal_ok;
        logic       stable_ok;
        logic       ready_low_ok;
        logic       never_valid;
        logic [7:0] held_bits;
        logic [7:0] held_unst;
        logic       held_xor;

        for (int i = 0; i < 8; i++) pat[i] = 8'h00;

        // 1: reset and idle
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_trigger", {31'd0, puf_trigger}, 32'd0);
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_outputs", {15'd0, resp_xor, resp_unstable, resp_bits}, 32'd0);
        chk("idle_challenge", {24'd0, puf_challenge}, 32'd0);

        // 2: constant 8'hC3 responses
        for (int i = 0; i < 8; i++) pat[i] = 8'hC3;
        base = fall_count;
        send_req(8'hA5);
        wait_resp(8'hA5, lat, chal_ok);
        chk("t2_latency", lat, 32'd51);
        chk("t2_bits", {24'd0, resp_bits}, 32'hC3);
        chk("t2_xor", {31'd0, resp_xor}, 32'd0);
        chk("t2_unstable", {24'd0, resp_unstable}, 32'd0);
        chk("t2_challenge_held", {31'd0, chal_ok}, 32'd1);
        finish_resp();
        @(negedge clk);

        // 3: chain 0 toggles across votes
        pat[0] = 8'h01; pat[1] = 8'h00; pat[2] = 8'h01; pat[3] = 8'h00; pat[4] = 8'h01;
        base = fall_count;
        send_req(8'h96);
        wait_resp(8'h96, lat, chal_ok);
        chk("t3_latency", lat, 32'd51);
        chk("t3_bits", {24'd0, resp_bits}, 32'h01);
        chk("t3_xor", {31'd0, resp_xor}, 32'd1);
        chk("t3_unstable", {24'd0, resp_unstable}, 32'h01);

        // 4: back-pressure on the result with an ignored second request
        held_bits = resp_bits;
        held_unst = resp_unstable;
        held_xor  = resp_xor;
        stable_ok = 1'b1;
        ready_low_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                req_challenge = 8'h3C;
                req_valid = 1'b1;
            end
            if (i == 11) req_valid = 1'b0;
            @(negedge clk);
            if (!resp_valid || resp_bits !== held_bits || resp_unstable !== held_unst
                || resp_xor !== held_xor) stable_ok = 1'b0;
            if (req_ready !== 1'b0) ready_low_ok = 1'b0;
        end
        chk("t4_outputs_stable", {31'd0, stable_ok}, 32'd1);
        chk("t4_req_ready_low", {31'd0, ready_low_ok}, 32'd1);
        chk("t4_req_not_taken", {24'd0, puf_challenge}, 32'h96);
        for (int i = 0; i < 8; i++) pat[i] = 8'hFF;
        base = fall_count;
        req_challenge = 8'h3C;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("t4_done_exit_valid", {31'd0, resp_valid}, 32'd0);
        chk("t4_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("t4_idle_challenge_old", {24'd0, puf_challenge}, 32'h96);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t4_accepted_ready", {31'd0, req_ready}, 32'd0);
        chk("t4_accepted_challenge", {24'd0, puf_challenge}, 32'h3C);

        // 5: reset during the third vote's trigger-high phase
        lat = 0;
        while (!((fall_count - base) == 2 && puf_trigger) && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk("t5_reach_vote3", {31'd0, puf_trigger}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_trigger_drop", {31'd0, puf_trigger}, 32'd0);
        chk("t5_ready_in_rst", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        never_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) never_valid = 1'b0;
        end
        chk("t5_no_resp_valid", {31'd0, never_valid}, 32'd1);
        for (int i = 0; i < 8; i++) pat[i] = 8'h0F;
        base = fall_count;
        send_req(8'h5A);
        wait_resp(8'h5A, lat, chal_ok);
        chk("t5_latency", lat, 32'd51);
        chk("t5_bits", {24'd0, resp_bits}, 32'h0F);
        chk("t5_unstable", {24'd0, resp_unstable}, 32'd0);
        chk("t5_xor", {31'd0, resp_xor}, 32'd0);
        finish_resp();

        // 6: single vote, one-cycle settle, four chains
        puf_resp2      = 4'b1010;
        req_challenge2 = 8'h77;
        req_valid2     = 1'b1;
        chk("t6_ready", {31'd0, req_ready2}, 32'd1);
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid2 && lat < 100);
        chk("t6_latency", lat, 32'd5);
        chk("t6_bits", {28'd0, resp_bits2}, 32'hA);
        chk("t6_unstable", {28'd0, resp_unstable2}, 32'd0);
        chk("t6_xor", {31'd0, resp_xor2}, 32'd0);
        chk("t6_challenge", {24'd0, puf_challenge2}, 32'h77);
        resp_ready2 = 1'b1;
        @(negedge clk);
        resp_ready2 = 1'b0;
        puf_resp2 = 4'b0111;
        @(negedge clk);
        req_challenge2 = 8'h11;
        req_valid2     = 1'b1;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid2 && lat < 100);
        chk("t6b_latency", lat, 32'd5);
        chk("t6b_bits", {28'd0, resp_bits2}, 32'h7);
        chk("t6b_xor", {31'd0, resp_xor2}, 32'd1);
        chk("t6b_unstable", {28'd0, resp_unstable2}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
